alu_exec_ctrl: RTL and testbench

//  Execute-stage sequencer directly upstream of alu: accepts one ALU request (op, two source regs, dest reg),

---
 rtl/alu_exec_pkg.sv | 19 +
 rtl/alu_exec_ctrl.sv | 144 ++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_pkg.sv
// Shared ALU operation and flag types used by the execute-stage controller and its alu.
package alu_exec_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_CMP = 3'd5
  } alu_op_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
  } alu_flag_t;

endpackage

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: reads two operands from a single-port regfile, drives alu, writes back.
// Optional last-write-back forwarding (skips the operand-A read) enabled by ALU_EXEC_FWD_EN.
module alu_exec_ctrl
  import alu_exec_pkg::*;
#(
  parameter int unsigned DATA_BUS_WIDTH = 8,
  parameter int unsigned REG_ADDR_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  alu_op_e                   req_op,
  input  logic [REG_ADDR_WIDTH-1:0] req_src1,
  input  logic [REG_ADDR_WIDTH-1:0] req_src2,
  input  logic [REG_ADDR_WIDTH-1:0] req_dst,
  input  logic                      req_wb_en,
  output logic [REG_ADDR_WIDTH-1:0] rf_raddr,
  input  logic [DATA_BUS_WIDTH-1:0] rf_rdata,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_BUS_WIDTH-1:0] rf_wdata,
  output alu_op_e                   alu_op,
  output logic [DATA_BUS_WIDTH-1:0] alu_a,
  output logic [DATA_BUS_WIDTH-1:0] alu_b,
  input  logic [DATA_BUS_WIDTH-1:0] alu_result,
  input  alu_flag_t                 alu_flag,
  output alu_flag_t                 flags,
  output logic                      done
);

  typedef enum logic [1:0] {S_IDLE, S_RDA, S_RDB, S_EXE} state_e;

  state_e                    r_state;
  logic                      r_done;
  logic                      r_we;
  logic [REG_ADDR_WIDTH-1:0] r_raddr;
  logic [REG_ADDR_WIDTH-1:0] r_src2_q;
  logic [REG_ADDR_WIDTH-1:0] r_dst_q;
  logic                      r_wb_en_q;
  logic                      r_a_fwd;
  logic [DATA_BUS_WIDTH-1:0] r_a_q;
  alu_op_e                   r_op_q;
  alu_flag_t                 r_flags;

  logic                      w_accept;
  logic                      w_fwd_hit;
  logic [DATA_BUS_WIDTH-1:0] w_fwd_val;

  assign req_ready = (r_state == S_IDLE) || (r_state == S_EXE);
  assign w_accept  = req_valid && req_ready;

`ifdef ALU_EXEC_FWD_EN
  logic                      r_fwd_valid;
  logic [REG_ADDR_WIDTH-1:0] r_fwd_dst;
  logic [DATA_BUS_WIDTH-1:0] r_fwd_data;
  logic                      w_fwd_exe;

  // The write committing this cycle is newer than the stored entry, so it wins.
  assign w_fwd_exe = (r_state == S_EXE) && r_wb_en_q && (req_src1 == r_dst_q);
  assign w_fwd_hit = w_fwd_exe || (r_fwd_valid && (req_src1 == r_fwd_dst));
  assign w_fwd_val = w_fwd_exe ? alu_result : r_fwd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwd_valid <= 1'b0;
      r_fwd_dst   <= '0;
      r_fwd_data  <= '0;
    end else if ((r_state == S_EXE) && r_wb_en_q) begin
      r_fwd_valid <= 1'b1;
      r_fwd_dst   <= r_dst_q;
      r_fwd_data  <= alu_result;
    end
  end
`else
  assign w_fwd_hit = 1'b0;
  assign w_fwd_val = '0;
`endif

  // Sequencer; done/rf_we are registered one state ahead so they are high throughout EXE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_done    <= 1'b0;
      r_we      <= 1'b0;
      r_raddr   <= '0;
      r_src2_q  <= '0;
      r_dst_q   <= '0;
      r_wb_en_q <= 1'b0;
      r_a_fwd   <= 1'b0;
      r_a_q     <= '0;
      r_op_q    <= ALU_ADD;
      r_flags   <= '0;
    end else begin
      r_done <= 1'b0;
      r_we   <= 1'b0;
      case (r_state)
        S_IDLE: r_state <= S_IDLE;
        S_RDA: begin
          r_raddr <= r_src2_q;
          r_state <= S_RDB;
        end
        S_RDB: begin
          if (!r_a_fwd) r_a_q <= rf_rdata;
          r_done  <= 1'b1;
          r_we    <= r_wb_en_q;
          r_state <= S_EXE;
        end
        S_EXE: begin
          r_flags <= alu_flag;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // Accept only happens in IDLE or EXE and overrides the state chosen above.
      if (w_accept) begin
        r_op_q    <= req_op;
        r_src2_q  <= req_src2;
        r_dst_q   <= req_dst;
        r_wb_en_q <= req_wb_en;
        r_a_fwd   <= w_fwd_hit;
        if (w_fwd_hit) begin
          r_a_q   <= w_fwd_val;
          r_raddr <= req_src2;
          r_state <= S_RDB;
        end else begin
          r_raddr <= req_src1;
          r_state <= S_RDA;
        end
      end
    end
  end

  assign rf_raddr = r_raddr;
  assign rf_we    = r_we;
  assign rf_waddr = r_dst_q;
  assign rf_wdata = alu_result;
  assign alu_op   = r_op_q;
  assign alu_a    = r_a_q;
  assign alu_b    = rf_rdata;
  assign flags    = r_flags;
  assign done     = r_done;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboard bench for alu_exec_ctrl with a behavioural regfile and alu around the DUT.
module tb_alu_exec_ctrl;
  import alu_exec_pkg::*;

  typedef struct packed {
    alu_flag_t  fl;
    logic [7:0] res;
  } alu_res_t;

  typedef struct {
    int         issue_cyc;
    int         lat;
    logic       wb;
    logic [1:0] dst;
    logic [7:0] res;
    alu_flag_t  fl;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  alu_op_e    req_op;
  logic [1:0] req_src1, req_src2, req_dst;
  logic       req_wb_en;
  logic [1:0] rf_raddr;
  logic [7:0] rf_rdata;
  logic       rf_we;
  logic [1:0] rf_waddr;
  logic [7:0] rf_wdata;
  alu_op_e    alu_op;
  logic [7:0] alu_a, alu_b, alu_result;
  alu_flag_t  alu_flag;
  alu_flag_t  flags;
  logic       done;

  logic       ld_en;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;
  logic [7:0] rf_mem [4];

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  exp_t       q[$];
  alu_flag_t  exp_flags;
  logic [7:0] m_rf [4];
  logic       m_fwd_valid;
  logic [1:0] m_fwd_dst;
  alu_res_t   w_alu;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_exec_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .req_dst(req_dst), .req_wb_en(req_wb_en),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_flag(alu_flag),
    .flags(flags), .done(done)
  );

  // ALU semantics from plain integer arithmetic; carry on SUB/CMP means borrow.
  function automatic alu_res_t alu_ref(input alu_op_e op, input logic [7:0] a, input logic [7:0] b);
    alu_res_t r;
    int ia, ib, v;
    ia = int'(a);
    ib = int'(b);
    r.fl.carry = 1'b0;
    case (op)
      ALU_ADD: begin v = ia + ib; r.fl.carry = (v > 255); end
      ALU_SUB, ALU_CMP: begin v = ia - ib; r.fl.carry = (ia < ib); end
      ALU_AND: v = ia & ib;
      ALU_OR:  v = ia | ib;
      ALU_XOR: v = ia ^ ib;
      default: v = 0;
    endcase
    r.res     = 8'(v);
    r.fl.zero = (r.res == 8'd0);
    r.fl.neg  = r.res[7];
    return r;
  endfunction

  assign w_alu      = alu_ref(alu_op, alu_a, alu_b);
  assign alu_result = w_alu.res;
  assign alu_flag   = w_alu.fl;

  // Regfile with one-cycle read latency; the bench preload port shares its write path.
  always @(posedge clk) begin
    rf_rdata <= rf_mem[rf_raddr];
    if (ld_en) rf_mem[ld_addr] <= ld_data;
    else if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse; flags must hold their last completed value.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      exp_flags = '0;
    end else begin
      check("flags_hold", 32'(flags), 32'(exp_flags));
      if (done) begin
        if (q.size() == 0) begin
          check("spurious_done", 32'(done), 32'd0);
        end else begin
          e = q.pop_front();
          check("latency", 32'(cyc - e.issue_cyc), 32'(e.lat));
          check("rf_we", 32'(rf_we), 32'(e.wb));
          if (e.wb) begin
            check("rf_waddr", 32'(rf_waddr), 32'(e.dst));
            check("rf_wdata", 32'(rf_wdata), 32'(e.res));
          end
          exp_flags = e.fl;
        end
      end else begin
        check("rf_we_outside_exe", 32'(rf_we), 32'd0);
      end
    end
  end

  task automatic init_rf(input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2, input logic [7:0] v3);
    logic [7:0] v [4];
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ld_en = 1'b1; ld_addr = 2'(i); ld_data = v[i]; m_rf[i] = v[i];
      @(posedge clk); #1;
    end
    ld_en = 1'b0;
    rst = 1'b0;
    m_fwd_valid = 1'b0;
  endtask

  // Called at posedge+1; garbage requests are driven while the DUT is not ready.
  task automatic issue(input alu_op_e op, input logic [1:0] s1, input logic [1:0] s2,
                       input logic [1:0] d, input logic wb);
    int n;
    exp_t e;
    alu_res_t r;
    logic hit;
    n = 0;
    while (!req_ready && n < 8) begin
      req_valid = 1'b1;
      req_op    = alu_op_e'(3'($urandom_range(0, 5)));
      req_src1  = 2'($urandom_range(0, 3));
      req_src2  = 2'($urandom_range(0, 3));
      req_dst   = 2'($urandom_range(0, 3));
      req_wb_en = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      check("ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    req_valid = 1'b1; req_op = op; req_src1 = s1; req_src2 = s2; req_dst = d; req_wb_en = wb;
    r   = alu_ref(op, m_rf[s1], m_rf[s2]);
    hit = 1'b0;
`ifdef ALU_EXEC_FWD_EN
    hit = m_fwd_valid && (m_fwd_dst == s1);
`endif
    e.issue_cyc = cyc;
    e.lat       = hit ? 2 : 3;
    e.wb        = wb;
    e.dst       = d;
    e.res       = r.res;
    e.fl        = r.fl;
    q.push_back(e);
    if (wb) begin
      m_rf[d]     = r.res;
      m_fwd_valid = 1'b1;
      m_fwd_dst   = d;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_raddr", 32'(rf_raddr), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] saved [4];
    logic       saved_valid;
    logic [1:0] saved_dst;
    rst = 1'b1; req_valid = 1'b0; req_op = ALU_ADD;
    req_src1 = '0; req_src2 = '0; req_dst = '0; req_wb_en = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    m_fwd_valid = 1'b0; m_fwd_dst = '0;

    init_rf(8'd0, 8'd3, 8'd5, 8'd0);
    check_reset_state();

    // 3 + 5 into R3
    issue(ALU_ADD, 2'd1, 2'd2, 2'd3, 1'b1);
    drain();
    check("add_r3", 32'(rf_mem[3]), 32'd8);

    // Compare-only of equal values sets zero and leaves R0 untouched
    init_rf(8'd0, 8'd7, 8'd7, 8'd0);
    issue(ALU_CMP, 2'd1, 2'd2, 2'd0, 1'b0);
    drain();
    check("cmp_zero", 32'(flags.zero), 32'd1);
    check("cmp_no_wb", 32'(rf_mem[0]), 32'd0);

    // Wrap-around: carry and zero both set
    init_rf(8'd0, 8'hFF, 8'h01, 8'd0);
    issue(ALU_ADD, 2'd1, 2'd2, 2'd3, 1'b1);
    drain();
    check("wrap_flags", 32'(flags), 32'b110);
    check("wrap_r3", 32'(rf_mem[3]), 32'd0);

    // Back-to-back with a RAW dependency on the previous destination
    init_rf(8'd0, 8'd3, 8'd5, 8'd0);
    issue(ALU_ADD, 2'd1, 2'd2, 2'd3, 1'b1);
    issue(ALU_ADD, 2'd3, 2'd1, 2'd0, 1'b1);
    drain();
    check("b2b_r0", 32'(rf_mem[0]), 32'd11);

    // Reset while the op sits in RDB: dropped without write-back or done
    init_rf(8'd0, 8'd3, 8'd5, 8'd9);
    foreach (m_rf[i]) saved[i] = m_rf[i];
    saved_valid = m_fwd_valid;
    saved_dst   = m_fwd_dst;
    issue(ALU_ADD, 2'd1, 2'd2, 2'd3, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    foreach (m_rf[i]) m_rf[i] = saved[i];
    m_fwd_valid = 1'b0;
    m_fwd_dst   = saved_valid ? saved_dst : 2'd0;
    check_reset_state();
    check("rst_no_wb", 32'(rf_mem[3]), 32'd9);

    // Randomized traffic with random gaps, including back-to-back accepts in EXE
    init_rf(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    for (int i = 0; i < 150; i++) begin
      issue(alu_op_e'(3'($urandom_range(0, 5))), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    drain();
    for (int i = 0; i < 4; i++) check("final_rf", 32'(rf_mem[i]), 32'(m_rf[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL global_timeout got %0d expected done", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
